// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (LEN, payload, CSUM) over a valid/ready
// handshake. It writes the payload into program/data memory through one write port and
// releases the core from reset only after the checksum matches.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-low reset
//   start      pulse to begin a new load (honoured in IDLE, DONE, ERR only)
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts in_data this cycle (decoded from the state register only)
//   mem_addr   write address
//   mem_data   write data
//   mem_write  one-cycle write strobe per payload byte
//   core_hold  1 holds the core in reset
//   busy       load in progress
//   done       last load succeeded, core released
//   err        last load failed its checksum
module prog_loader #(
  parameter int unsigned         ADDR_W    = 8,
  parameter int unsigned         DATA_W    = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StLen, StLoad, StCsum, StDone, StErr} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = 1;

  state_e              state_q;
  logic [8:0]          count_q;  // 9 bits so a LEN of 0 can stand for 256 bytes
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   sum_q;
  logic                accept;
  logic [7:0]          len_byte;
  logic [8:0]          len_n;

  always_comb begin
    in_ready = (state_q == StLen) || (state_q == StLoad) || (state_q == StCsum);
    accept   = in_valid && in_ready;
    len_byte = in_data[7:0];
    len_n    = (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLen;
            busy    <= 1'b1;
          end
        end
        StLen: begin
          if (accept) begin
            count_q <= len_n;
            addr_q  <= BASE_ADDR;
            sum_q   <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (accept) begin
            mem_write <= 1'b1;
            mem_addr  <= addr_q;
            mem_data  <= in_data;
            sum_q     <= sum_q + in_data;
            addr_q    <= addr_q + AddrOne;  // wraps silently at the top of memory
            count_q   <= count_q - 9'd1;
            if (count_q == 9'd1) state_q <= StCsum;
          end
        end
        StCsum: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_data == sum_q) begin
              state_q   <= StDone;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
            end
          end
        end
        StDone, StErr: begin
          if (start) begin
            state_q   <= StLen;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            core_hold <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x00 and base 0x80) driven by one stream,
// each write strobe logged and compared against the expected image of the frame.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       in_ready0, mem_write0, core_hold0, busy0, done0, err0;
  logic [7:0] mem_addr0, mem_data0;
  logic       in_ready1, mem_write1, core_hold1, busy1, done1, err1;
  logic [7:0] mem_addr1, mem_data1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int         wc0[$], wc1[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .mem_write(mem_write0), .core_hold(core_hold0), .busy(busy0), .done(done0), .err(err0)
  );

  prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h80)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .mem_write(mem_write1), .core_hold(core_hold1), .busy(busy1), .done(done1), .err(err1)
  );

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (mem_write0) begin wa0.push_back(mem_addr0); wd0.push_back(mem_data0); wc0.push_back(cyc); end
    if (mem_write1) begin wa1.push_back(mem_addr1); wd1.push_back(mem_data1); wc1.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wc0.delete();
    wa1.delete(); wd1.delete(); wc1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int t;
    for (int k = 0; k < 4 && int'($urandom_range(99)) < stall_pct; k++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready0) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Full load of one frame, then compare the write log and status against the model.
  task automatic run_frame(input logic [7:0] pl[$], input logic [7:0] csum,
                           input int stall_pct, input bit poke_start);
    int         n;
    int         m;
    logic [7:0] sum;
    bit         ok;
    n   = pl.size();
    sum = 8'h00;
    foreach (pl[i]) sum = sum + pl[i];
    ok = (sum == csum);
    clear_log();
    pulse_start();
    check("start_busy", 32'(busy0), 32'd1);
    check("start_hold", 32'(core_hold0), 32'd1);
    check("start_done", 32'(done0), 32'd0);
    check("start_err", 32'(err0), 32'd0);
    send_byte(8'(n), stall_pct);
    for (int i = 0; i < n; i++) begin
      if (poke_start && i == n / 2) start = 1'b1;
      send_byte(pl[i], stall_pct);
      start = 1'b0;
    end
    send_byte(csum, stall_pct);
    in_valid = 1'b0;
    check("end_done0", 32'(done0), 32'(ok));
    check("end_err0", 32'(err0), 32'(!ok));
    check("end_hold0", 32'(core_hold0), 32'(!ok));
    check("end_busy0", 32'(busy0), 32'd0);
    check("end_done1", 32'(done1), 32'(ok));
    check("end_hold1", 32'(core_hold1), 32'(!ok));
    check("wr_count0", 32'(wa0.size()), 32'(n));
    check("wr_count1", 32'(wa1.size()), 32'(n));
    m = (wa0.size() < n) ? wa0.size() : n;
    for (int i = 0; i < m; i++) begin
      check("wr_addr0", 32'(wa0[i]), 32'((i + 'h00) % 256));
      check("wr_data0", 32'(wd0[i]), 32'(pl[i]));
    end
    m = (wa1.size() < n) ? wa1.size() : n;
    for (int i = 0; i < m; i++) begin
      check("wr_addr1", 32'(wa1[i]), 32'((i + 'h80) % 256));
      check("wr_data1", 32'(wd1[i]), 32'(pl[i]));
    end
    if (stall_pct == 0 && wc0.size() == n && n > 0)
      check("wr_back_to_back", 32'(wc0[n-1] - wc0[0]), 32'(n - 1));
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] s;
    int         len;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready0), 32'd0);
    check("rst_write", 32'(mem_write0), 32'd0);
    check("rst_addr", 32'(mem_addr0), 32'd0);
    check("rst_data", 32'(mem_data0), 32'd0);
    check("rst_hold", 32'(core_hold0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready0), 32'd0);

    // Bytes offered in IDLE are not consumed
    in_data = 8'h5a; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_no_write", 32'(wa0.size()), 32'd0);
    check("idle_busy", 32'(busy0), 32'd0);

    // Reset in the middle of a load
    clear_log();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_hold", 32'(core_hold0), 32'd1);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_write", 32'(mem_write0), 32'd0);
    check("mid_rst_ready", 32'(in_ready0), 32'd0);
    check("mid_rst_addr", 32'(mem_addr0), 32'd0);
    check("mid_rst_writes", 32'(wa0.size()), 32'd2);
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_frame(pl, 8'hA1 + 8'hB2 + 8'hC3 + 8'hD4, 0, 1'b0);

    // Basic load, back-to-back
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(pl, 8'h66, 0, 1'b0);

    // Checksum failure, then a good frame clears err
    run_frame(pl, 8'h67, 0, 1'b0);
    run_frame(pl, 8'h66, 0, 1'b0);

    // LEN 0 means 256 bytes; addresses wrap for the 0x80 instance
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'h01);
    run_frame(pl, 8'h00, 0, 1'b0);

    // Random stalls with a start pulse in the middle of LOAD
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    run_frame(pl, s, 50, 1'b1);

    // Reload straight from DONE (run_frame checks hold/done right after start)
    pl = '{8'h07, 8'h08};
    run_frame(pl, 8'h0f, 0, 1'b0);

    // Random frames, some with a corrupted checksum
    for (int f = 0; f < 4; f++) begin
      len = int'($urandom_range(40, 1));
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      s = 8'h00;
      foreach (pl[i]) s = s + pl[i];
      if ($urandom_range(2) == 0) s = s ^ 8'h01;
      run_frame(pl, s, 25, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
